occ_fetch: RTL and testbench
============================

# occ_fetch

Downstream neighbour of the k/l calculation stage in the backward-extension pipeline. It accepts the stage's per-token memory request (occurrence-line addresses for k and l plus the packed token sideband) and buffers it in an in-order queue. It issues one or two cache-line reads per token and pairs the returned 512-bit lines with their token. Completed tokens are presented, in order, to the occurrence-count stage; upstream is back-pressured through `stall`.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥4.
- `ADDR_W`, 42: line address width.
- `TOKEN_W`, 512: packed token sideband width (status, read_num, backward_k/l, p_x*, counters, …).
- `CL`, 512: memory line width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: token present; driven as upstream request_valid & !stall.
- `in_addr_k` in ADDR_W: line address for k.
- `in_addr_l` in ADDR_W: line address for l.
- `in_token` in TOKEN_W: sideband; stored and returned untouched.
- `stall` out 1: registered back-pressure to the k/l stage and everything above it.
- `mem_req_valid` out 1: read request valid.
- `mem_req_addr` out ADDR_W: read line address.
- `mem_req_ready` in 1: memory accepts request.
- `mem_rsp_valid` in 1: read data valid; responses return in request order, with no back-pressure.
- `mem_rsp_data` in CL: returned line.
- `out_valid` out 1: completed token available.
- `out_token` out TOKEN_W: token sideband.
- `out_line_k` out CL: line for k.
- `out_line_l` out CL: line for l.
- `out_ready` in 1: consumer accepts.
- `err_rsp` out 1: sticky; a response arrived with nothing outstanding.

## Operation
- Per entry, store token, addr_k, addr_l, `same` = (addr_k == addr_l), line_k, line_l, and `done`.
- Pointers use log2(DEPTH)+1 bits and wrap modulo 2·DEPTH:
  - `wr_ptr`: push.
  - `iss_ptr` plus `iss_ph` (0 = k, 1 = l): request issue.
  - `rsp_ptr` plus `rsp_ph`: response fill.
  - `rd_ptr`: pop.
- Push: `in_valid` writes entry[wr_ptr] and increments wr_ptr. A push while full is impossible by stall slack; the bench asserts this never happens.
- Issue FSM, states IDLE / REQ_K / REQ_L:
  - IDLE → REQ_K when iss_ptr ≠ wr_ptr.
  - REQ_K: drive addr_k. On ready, go to REQ_L if !same; if same, advance iss_ptr and go to REQ_K or IDLE.
  - REQ_L: drive addr_l. On ready, advance iss_ptr and go to REQ_K or IDLE.
  - `mem_req_valid` and `mem_req_addr` are registered and stay stable while !ready.
- Response fill, applied to entry[rsp_ptr]:
  - rsp_ph = 0: write line_k; if same, also write line_l, set done, advance rsp_ptr. Otherwise set rsp_ph = 1.
  - rsp_ph = 1: write line_l, set done, advance rsp_ptr, clear rsp_ph.
  - A response while rsp_ptr == iss_ptr and rsp_ph = 0 and no request is outstanding is dropped and sets err_rsp.
- Pop: `out_valid` = entry[rd_ptr].done && rd_ptr ≠ wr_ptr. On out_valid & out_ready, clear done and increment rd_ptr. Outputs are read combinationally from entry[rd_ptr].
- Occupancy = wr_ptr − rd_ptr.
- `stall` is registered as (occupancy_next ≥ DEPTH−2). The two entries of slack absorb the upstream register plus the stall register.

## Timing
- Reset values: stall 0, mem_req_valid 0, mem_req_addr 0, out_valid 0, err_rsp 0; all pointers and phases 0; all done bits 0; FSM IDLE.
- Token pushed at edge t → mem_req_valid at t+1 at the earliest.
- Response captured at edge r → out_valid high after r, in the same cycle the entry becomes done.
- Zero-stall throughput: 1 token per cycle when all tokens have same = 1; 1 token per 2 cycles otherwise (request-port bound).
- Simultaneous push, pop, issue and fill in one cycle are all legal. Occupancy is unchanged on push+pop. A fill and a pop never target the same entry, because pop requires done.
- Wrap-around: pointer equality including the wrap bit means empty; a difference of DEPTH means full.
- rst mid-operation clears all state next edge. The memory must be quiescent before rst is released; stray responses after reset set err_rsp.
- stall deasserts the cycle after occupancy_next drops below DEPTH−2.

## Test plan
- Single token, addr_k = 0x100, addr_l = 0x101, ready = 1 → requests 0x100 then 0x101 on consecutive cycles; responses A, B → out_line_k = A, out_line_l = B, token unchanged, out_valid one cycle.
- Token with addr_k = addr_l = 0x2A0 → exactly one request; response C → out_line_k = out_line_l = C.
- out_ready = 0, 10 tokens back-to-back, DEPTH = 8 → stall asserts when occupancy reaches 6. No entry is overwritten. Releasing out_ready drains all 10 tokens in order.
- mem_req_ready held low 5 cycles mid-REQ_L → mem_req_addr stable for those cycles, no duplicate or lost request.
- 20 tokens with random same flags and random response delays, so pointers wrap twice → all outputs in input order, each with the correct line pairing.
- Unsolicited mem_rsp_valid after reset → err_rsp = 1 and stays set; out_valid stays 0; rst clears err_rsp.

Source files
------------

// File: rtl/occ_fetch.sv
// occ_fetch: in-order token queue between the k/l calculation stage and the occurrence-count stage.
// Issues one or two occurrence-line reads per token and pairs the returned lines with their token.
module occ_fetch #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 42,
  parameter int TOKEN_W = 512,
  parameter int CL      = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr_k,
  input  logic [ADDR_W-1:0]  in_addr_l,
  input  logic [TOKEN_W-1:0] in_token,
  output logic               stall,
  output logic               mem_req_valid,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [CL-1:0]      mem_rsp_data,
  output logic               out_valid,
  output logic [TOKEN_W-1:0] out_token,
  output logic [CL-1:0]      out_line_k,
  output logic [CL-1:0]      out_line_l,
  input  logic               out_ready,
  output logic               err_rsp
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_K = 2'd1,
    REQ_L = 2'd2
  } iss_state_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready; once raised, the
  // request valid/addr hold until accepted. Responses and pushes carry no ready: they always land.

  logic [TOKEN_W-1:0] token_q  [DEPTH];
  logic [TOKEN_W-1:0] token_d  [DEPTH];
  logic [ADDR_W-1:0]  addr_k_q [DEPTH];
  logic [ADDR_W-1:0]  addr_k_d [DEPTH];
  logic [ADDR_W-1:0]  addr_l_q [DEPTH];
  logic [ADDR_W-1:0]  addr_l_d [DEPTH];
  logic [CL-1:0]      line_k_q [DEPTH];
  logic [CL-1:0]      line_k_d [DEPTH];
  logic [CL-1:0]      line_l_q [DEPTH];
  logic [CL-1:0]      line_l_d [DEPTH];
  logic [DEPTH-1:0]   same_q, same_d;
  logic [DEPTH-1:0]   done_q, done_d;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      iss_ptr_q, iss_ptr_d;
  logic [PW-1:0]      rsp_ptr_q, rsp_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               rsp_ph_q, rsp_ph_d;
  logic [CW-1:0]      outst_q, outst_d;
  iss_state_e         state_q, state_d;
  logic               mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic               stall_q, stall_d;
  logic               err_rsp_q, err_rsp_d;

  logic [AW-1:0]      wr_idx, iss_idx, iss_idx_d, rsp_idx, rd_idx;
  logic               req_fire, rsp_take, pop;
  logic [PW-1:0]      occ_next;

  assign wr_idx    = wr_ptr_q[AW-1:0];
  assign iss_idx   = iss_ptr_q[AW-1:0];
  assign iss_idx_d = iss_ptr_d[AW-1:0];
  assign rsp_idx   = rsp_ptr_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];

  assign req_fire  = mem_req_valid_q && mem_req_ready;
  // A response with nothing outstanding has no entry to land in and is dropped.
  assign rsp_take  = mem_rsp_valid && (outst_q != '0);
  assign out_valid = done_q[rd_idx] && (rd_ptr_q != wr_ptr_q);
  assign pop       = out_valid && out_ready;

  assign out_token     = token_q[rd_idx];
  assign out_line_k    = line_k_q[rd_idx];
  assign out_line_l    = line_l_q[rd_idx];
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign stall         = stall_q;
  assign err_rsp       = err_rsp_q;

  // Queue storage, fill, pop and occupancy bookkeeping.
  always_comb begin
    token_d   = token_q;
    addr_k_d  = addr_k_q;
    addr_l_d  = addr_l_q;
    line_k_d  = line_k_q;
    line_l_d  = line_l_q;
    same_d    = same_q;
    done_d    = done_q;
    wr_ptr_d  = wr_ptr_q;
    rsp_ptr_d = rsp_ptr_q;
    rsp_ph_d  = rsp_ph_q;
    rd_ptr_d  = rd_ptr_q;
    err_rsp_d = err_rsp_q;
    outst_d   = outst_q;

    if (in_valid) begin
      token_d[wr_idx]  = in_token;
      addr_k_d[wr_idx] = in_addr_k;
      addr_l_d[wr_idx] = in_addr_l;
      same_d[wr_idx]   = (in_addr_k == in_addr_l);
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (mem_rsp_valid && !rsp_take) begin
      err_rsp_d = 1'b1;
    end else if (rsp_take) begin
      if (!rsp_ph_q) begin
        line_k_d[rsp_idx] = mem_rsp_data;
        if (same_q[rsp_idx]) begin
          line_l_d[rsp_idx] = mem_rsp_data;
          done_d[rsp_idx]   = 1'b1;
          rsp_ptr_d         = rsp_ptr_q + PW'(1);
        end else begin
          rsp_ph_d = 1'b1;
        end
      end else begin
        line_l_d[rsp_idx] = mem_rsp_data;
        done_d[rsp_idx]   = 1'b1;
        rsp_ptr_d         = rsp_ptr_q + PW'(1);
        rsp_ph_d          = 1'b0;
      end
    end

    if (pop) begin
      done_d[rd_idx] = 1'b0;
      rd_ptr_d       = rd_ptr_q + PW'(1);
    end

    case ({req_fire, rsp_take})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    occ_next = wr_ptr_d - rd_ptr_d;
    stall_d  = (occ_next >= PW'(DEPTH - 2));
  end

  // Issue FSM: next state and issue pointer.
  always_comb begin
    state_d   = state_q;
    iss_ptr_d = iss_ptr_q;
    case (state_q)
      IDLE: begin
        if (iss_ptr_q != wr_ptr_q) state_d = REQ_K;
      end
      REQ_K: begin
        if (mem_req_ready) begin
          if (!same_q[iss_idx]) begin
            state_d = REQ_L;
          end else begin
            iss_ptr_d = iss_ptr_q + PW'(1);
            state_d   = (iss_ptr_d != wr_ptr_q) ? REQ_K : IDLE;
          end
        end
      end
      REQ_L: begin
        if (mem_req_ready) begin
          iss_ptr_d = iss_ptr_q + PW'(1);
          state_d   = (iss_ptr_d != wr_ptr_q) ? REQ_K : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue FSM outputs, registered so the request port is glitch-free and holds while stalled.
  always_comb begin
    mem_req_valid_d = (state_d != IDLE);
    mem_req_addr_d  = mem_req_addr_q;
    case (state_d)
      REQ_K:   mem_req_addr_d = addr_k_q[iss_idx_d];
      REQ_L:   mem_req_addr_d = addr_l_q[iss_idx_d];
      default: mem_req_addr_d = mem_req_addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      iss_ptr_q       <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      iss_ptr_q       <= iss_ptr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rsp_ptr_q <= '0;
      rsp_ph_q  <= 1'b0;
      rd_ptr_q  <= '0;
      outst_q   <= '0;
      done_q    <= '0;
      stall_q   <= 1'b0;
      err_rsp_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      rsp_ph_q  <= rsp_ph_d;
      rd_ptr_q  <= rd_ptr_d;
      outst_q   <= outst_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
      err_rsp_q <= err_rsp_d;
    end
  end

  // Payload storage needs no reset: done bits and pointers gate every use of it.
  always_ff @(posedge clk) begin
    token_q  <= token_d;
    addr_k_q <= addr_k_d;
    addr_l_q <= addr_l_d;
    line_k_q <= line_k_d;
    line_l_q <= line_l_d;
    same_q   <= same_d;
  end

endmodule

// File: tb/tb_occ_fetch.sv
// Bench for occ_fetch: table vectors, hand-written corner sequences and randomized traffic
// checked against a queue-based model of the token stream and an in-order memory.
module tb_occ_fetch;

  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 42;
  localparam int TOKEN_W = 512;
  localparam int CL      = 512;

  typedef struct {
    logic [ADDR_W-1:0]  ak;
    logic [ADDR_W-1:0]  al;
    logic [TOKEN_W-1:0] tok;
  } tok_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } pend_t;

  typedef struct {
    logic [ADDR_W-1:0] ak;
    logic [ADDR_W-1:0] al;
    int                exp_nreq;
  } vec_t;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [ADDR_W-1:0]  in_addr_k;
  logic [ADDR_W-1:0]  in_addr_l;
  logic [TOKEN_W-1:0] in_token;
  logic               stall;
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_rsp_valid;
  logic [CL-1:0]      mem_rsp_data;
  logic               out_valid;
  logic [TOKEN_W-1:0] out_token;
  logic [CL-1:0]      out_line_k;
  logic [CL-1:0]      out_line_l;
  logic               out_ready;
  logic               err_rsp;

  occ_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TOKEN_W(TOKEN_W), .CL(CL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr_k(in_addr_k), .in_addr_l(in_addr_l),
    .in_token(in_token), .stall(stall), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_token(out_token), .out_line_k(out_line_k), .out_line_l(out_line_l),
    .out_ready(out_ready), .err_rsp(err_rsp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests, n_fail, cyc;
  tok_t              up_q[$];
  tok_t              exp_q[$];
  logic [ADDR_W-1:0] req_q[$];
  pend_t             pend_q[$];
  int                req_cyc_q[$];
  int occ, max_occ;
  int ready_pct, oready_pct, max_delay;
  bit inject_rsp;
  int n_req, n_out, n_outv, push_cyc, last_rsp_cyc, last_out_cyc;

  function automatic logic [CL-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [CL-1:0] l;
    for (int i = 0; i < CL / 64; i++) l[i*64 +: 64] = {22'(i), a} ^ 64'hC3A5_0000_0000_0000;
    return l;
  endfunction

  function automatic logic [TOKEN_W-1:0] rand_token();
    logic [TOKEN_W-1:0] t;
    for (int i = 0; i < TOKEN_W / 32; i++) t[i*32 +: 32] = $urandom();
    return t;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'({$urandom(), $urandom()});
  endfunction

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_addr_k = '0; in_addr_l = '0; in_token = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    up_q.delete(); exp_q.delete(); req_q.delete(); pend_q.delete(); req_cyc_q.delete();
    occ = 0; max_occ = 0;
  endtask

  // ---------------- driver / memory model / scoreboard, one cycle ----------------
  task automatic tick();
    bit drove_pend;
    logic [ADDR_W-1:0] ra;
    check("stall_vs_occupancy", CL'(stall), CL'(occ >= DEPTH - 2));
    if (out_valid && exp_q.size() == 0) check("out_valid_when_empty", CL'(out_valid), CL'(0));

    in_valid = (up_q.size() != 0) && !stall;
    if (in_valid) begin
      in_addr_k = up_q[0].ak; in_addr_l = up_q[0].al; in_token = up_q[0].tok;
    end
    mem_req_ready = ($urandom_range(0, 99) < ready_pct);
    drove_pend = 1'b0;
    mem_rsp_valid = 1'b0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = line_of(pend_q[0].addr); drove_pend = 1'b1;
    end else if (inject_rsp) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = rand_token(); inject_rsp = 1'b0;
    end
    out_ready = ($urandom_range(0, 99) < oready_pct);

    if (in_valid) begin
      check("push_not_full", CL'(occ < DEPTH), CL'(1));
      exp_q.push_back(up_q[0]);
      req_q.push_back(up_q[0].ak);
      if (up_q[0].ak != up_q[0].al) req_q.push_back(up_q[0].al);
      up_q.pop_front();
      occ++; push_cyc = cyc;
      if (occ > max_occ) max_occ = occ;
    end
    if (mem_req_valid && mem_req_ready) begin
      if (req_q.size() == 0) begin
        check("unexpected_request", CL'(mem_req_valid), CL'(0));
      end else begin
        ra = req_q.pop_front();
        check("req_addr", CL'(mem_req_addr), CL'(ra));
      end
      pend_q.push_back('{addr: mem_req_addr, due: cyc + 1 + int'($urandom_range(0, max_delay))});
      n_req++; req_cyc_q.push_back(cyc);
    end
    if (drove_pend) begin
      void'(pend_q.pop_front());
      last_rsp_cyc = cyc;
    end
    if (out_valid) n_outv++;
    if (out_valid && out_ready && exp_q.size() != 0) begin
      check("out_token", out_token, exp_q[0].tok);
      check("out_line_k", out_line_k, line_of(exp_q[0].ak));
      check("out_line_l", out_line_l, line_of(exp_q[0].al));
      void'(exp_q.pop_front());
      occ--; n_out++; last_out_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0 || pend_q.size() != 0) && guard < 3000) begin
      tick();
      guard++;
    end
    check({name, "_tokens_left"}, CL'(exp_q.size() + up_q.size()), CL'(0));
    check({name, "_requests_left"}, CL'(req_q.size()), CL'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    tok_t t;
    n_tests = 0; n_fail = 0; cyc = 0;
    ready_pct = 100; oready_pct = 100; max_delay = 0; inject_rsp = 1'b0;
    n_req = 0; n_out = 0; n_outv = 0; push_cyc = 0; last_rsp_cyc = 0; last_out_cyc = 0;

    do_reset();
    check("rst_stall", CL'(stall), CL'(0));
    check("rst_mem_req_valid", CL'(mem_req_valid), CL'(0));
    check("rst_mem_req_addr", CL'(mem_req_addr), CL'(0));
    check("rst_out_valid", CL'(out_valid), CL'(0));
    check("rst_err_rsp", CL'(err_rsp), CL'(0));

    // Isolated tokens: request count, issue latency, back-to-back requests, fill-to-out latency.
    vecs[0] = '{ak: 42'h100,         al: 42'h101,         exp_nreq: 2};
    vecs[1] = '{ak: 42'h2A0,         al: 42'h2A0,         exp_nreq: 1};
    vecs[2] = '{ak: 42'h0,           al: 42'h0,           exp_nreq: 1};
    vecs[3] = '{ak: {ADDR_W{1'b1}},  al: 42'h0,           exp_nreq: 2};
    vecs[4] = '{ak: 42'h3_FFFF_0000, al: 42'h3_FFFF_0001, exp_nreq: 2};
    vecs[5] = '{ak: 42'h55,          al: 42'h55,          exp_nreq: 1};
    for (int i = 0; i < 6; i++) begin
      t.ak = vecs[i].ak; t.al = vecs[i].al; t.tok = rand_token();
      n_req = 0; n_outv = 0; req_cyc_q.delete(); max_delay = i % 3;
      up_q.push_back(t);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_nreq", i), CL'(n_req), CL'(vecs[i].exp_nreq));
      check($sformatf("vec%0d_out_valid_cycles", i), CL'(n_outv), CL'(1));
      check($sformatf("vec%0d_out_after_rsp", i), CL'(last_out_cyc - last_rsp_cyc), CL'(1));
      if (req_cyc_q.size() != 0)
        check($sformatf("vec%0d_req_latency", i), CL'(req_cyc_q[0] - push_cyc), CL'(2));
      if (vecs[i].exp_nreq == 2 && req_cyc_q.size() == 2)
        check($sformatf("vec%0d_req_back_to_back", i), CL'(req_cyc_q[1] - req_cyc_q[0]), CL'(1));
    end

    // Consumer blocked: stall must cap occupancy at DEPTH-2, then all 10 drain in order.
    oready_pct = 0; ready_pct = 100; max_delay = 2; max_occ = 0; n_out = 0;
    for (int i = 0; i < 10; i++) begin
      t.ak = rand_addr(); t.al = t.ak ^ ADDR_W'(i + 1); t.tok = rand_token();
      up_q.push_back(t);
    end
    repeat (40) tick();
    check("stall_max_occupancy", CL'(max_occ), CL'(DEPTH - 2));
    check("stall_held", CL'(stall), CL'(1));
    check("stall_tokens_waiting", CL'(up_q.size()), CL'(4));
    oready_pct = 100;
    drain("stall_drain");
    check("stall_drained_count", CL'(n_out), CL'(10));
    check("stall_released", CL'(stall), CL'(0));

    // Memory refuses the l request for 5 cycles: request must hold steady, no loss or repeat.
    ready_pct = 100; max_delay = 1; n_req = 0;
    t.ak = 42'h300; t.al = 42'h301; t.tok = rand_token();
    up_q.push_back(t);
    for (int g = 0; g < 20 && n_req < 1; g++) tick();
    ready_pct = 0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", CL'(mem_req_valid), CL'(1));
      check("hold_addr", CL'(mem_req_addr), CL'(42'h301));
      tick();
    end
    ready_pct = 100;
    drain("hold_drain");
    check("hold_nreq", CL'(n_req), CL'(2));

    // Randomized traffic: random same flags, ready, delays and consumer; pointers wrap.
    for (int pass = 0; pass < 2; pass++) begin
      ready_pct = (pass == 0) ? 70 : 40;
      oready_pct = (pass == 0) ? 60 : 85;
      max_delay = (pass == 0) ? 6 : 3;
      n_out = 0;
      for (int i = 0; i < 20 + pass * 40; i++) begin
        t.ak = rand_addr();
        t.al = ($urandom_range(0, 1) == 1) ? t.ak : t.ak + ADDR_W'($urandom_range(1, 64));
        t.tok = rand_token();
        up_q.push_back(t);
      end
      drain($sformatf("random%0d", pass));
      check($sformatf("random%0d_count", pass), CL'(n_out), CL'(20 + pass * 40));
    end

    // Reset mid-operation (memory quiescent): completed but unconsumed tokens vanish.
    oready_pct = 0; ready_pct = 100; max_delay = 2;
    for (int i = 0; i < 5; i++) begin
      t.ak = rand_addr(); t.al = t.ak + ADDR_W'(1); t.tok = rand_token();
      up_q.push_back(t);
    end
    for (int g = 0; g < 200 && (up_q.size() != 0 || req_q.size() != 0 || pend_q.size() != 0); g++) tick();
    check("midrst_out_valid_before", CL'(out_valid), CL'(1));
    do_reset();
    check("midrst_out_valid", CL'(out_valid), CL'(0));
    check("midrst_mem_req_valid", CL'(mem_req_valid), CL'(0));
    oready_pct = 100; n_out = 0;
    t.ak = 42'h777; t.al = 42'h778; t.tok = rand_token();
    up_q.push_back(t);
    drain("midrst_after");
    check("midrst_after_count", CL'(n_out), CL'(1));

    // Unsolicited response after reset: sticky err_rsp, no output, cleared by rst.
    do_reset();
    check("err_clear_before", CL'(err_rsp), CL'(0));
    inject_rsp = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("err_sticky", CL'(err_rsp), CL'(1));
      check("err_no_out_valid", CL'(out_valid), CL'(0));
      tick();
    end
    do_reset();
    check("err_cleared_by_rst", CL'(err_rsp), CL'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
